// File: rtl/cload_arbiter_if.sv
// Bundle of client-request, grant/done and counter-control signals around cload_arbiter.
// The slave side is the arbiter; the master side is the clients plus the counter instance.
interface cload_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic [WIDTH-1:0] start0;
  logic [WIDTH-1:0] end0;
  logic             req1;
  logic [WIDTH-1:0] start1;
  logic [WIDTH-1:0] end1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             busy;
  logic             ctr_load;
  logic [WIDTH-1:0] ctr_load_h;
  logic [WIDTH-1:0] ctr_count;

  modport master (
    output req0, start0, end0, req1, start1, end1, ctr_count,
    input  gnt0, gnt1, done0, done1, busy, ctr_load, ctr_load_h
  );

  modport slave (
    input  req0, start0, end0, req1, start1, end1, ctr_count,
    output gnt0, gnt1, done0, done1, busy, ctr_load, ctr_load_h
  );
endinterface

// File: rtl/cload_arbiter.sv
// Two-requester round-robin arbiter that owns a shared loadable up-counter:
// loads the granted start value, waits for the count to hit the end value, then pulses done.
module cload_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  cload_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             owner;
  logic             owner_nxt;
  logic             rr_ptr;
  logic             rr_ptr_nxt;
  logic [WIDTH-1:0] end_q;
  logic [WIDTH-1:0] end_nxt;

  logic             gnt0_q,  gnt0_nxt;
  logic             gnt1_q,  gnt1_nxt;
  logic             done0_q, done0_nxt;
  logic             done1_q, done1_nxt;
  logic             busy_q,  busy_nxt;
  logic             load_q,  load_nxt;
  logic [WIDTH-1:0] load_h_q, load_h_nxt;

  logic             pick1;
  logic             owner_req;

  // rr_ptr set means requester 1 wins a tie; a lone request always wins.
  assign pick1     = bus.req1 & (~bus.req0 | rr_ptr);
  assign owner_req = owner ? bus.req1 : bus.req0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      rr_ptr   <= 1'b0;
      end_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      load_q   <= 1'b0;
      load_h_q <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      end_q    <= end_nxt;
      gnt0_q   <= gnt0_nxt;
      gnt1_q   <= gnt1_nxt;
      done0_q  <= done0_nxt;
      done1_q  <= done1_nxt;
      busy_q   <= busy_nxt;
      load_q   <= load_nxt;
      load_h_q <= load_h_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    end_nxt    = end_q;
    gnt0_nxt   = gnt0_q;
    gnt1_nxt   = gnt1_q;
    done0_nxt  = 1'b0;
    done1_nxt  = 1'b0;
    busy_nxt   = busy_q;
    load_nxt   = 1'b0;
    load_h_nxt = load_h_q;

    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_nxt  = LOAD;
          owner_nxt  = pick1;
          end_nxt    = pick1 ? bus.end1 : bus.end0;
          load_h_nxt = pick1 ? bus.start1 : bus.start0;
          load_nxt   = 1'b1;
          gnt0_nxt   = ~pick1;
          gnt1_nxt   = pick1;
          busy_nxt   = 1'b1;
        end
      end

      LOAD, RUN: begin
        // A dropped request aborts the run silently; it still counts as this requester's turn.
        if (!owner_req) begin
          state_nxt  = IDLE;
          gnt0_nxt   = 1'b0;
          gnt1_nxt   = 1'b0;
          busy_nxt   = 1'b0;
          rr_ptr_nxt = ~owner;
        end else if (state == LOAD) begin
          state_nxt = RUN;
        end else if (bus.ctr_count == end_q) begin
          state_nxt = DONE;
          done0_nxt = ~owner;
          done1_nxt = owner;
        end
      end

      DONE: begin
        state_nxt  = IDLE;
        gnt0_nxt   = 1'b0;
        gnt1_nxt   = 1'b0;
        busy_nxt   = 1'b0;
        rr_ptr_nxt = ~owner;
      end

      default: begin
        state_nxt = IDLE;
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.done0      = done0_q;
  assign bus.done1      = done1_q;
  assign bus.busy       = busy_q;
  assign bus.ctr_load   = load_q;
  assign bus.ctr_load_h = load_h_q;

endmodule

// File: tb/tb_cload_arbiter.sv
// Self-checking bench for cload_arbiter: a transaction-timeline model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cload_arbiter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] count = '0;
  bit               cmp_en = 1'b0;
  int               n_checks = 0;
  int               n_errors = 0;

  cload_arbiter_if #(.WIDTH(WIDTH)) bus ();

  cload_arbiter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Shared counter: loads on load, otherwise free-runs with wrap.
  always @(posedge clk) begin
    if (bus.ctr_load) count <= bus.ctr_load_h;
    else              count <= count + 1'b1;
  end
  assign bus.ctr_count = count;

  // Timeline model: a run owns the counter for 1 load cycle, d+1 run cycles and 1 done cycle.
  bit               m_active = 1'b0;
  bit               m_owner  = 1'b0;
  bit               m_ptr    = 1'b0;
  int               m_elapsed = 0;
  int               m_len     = 0;
  logic [WIDTH-1:0] m_load_h  = '0;

  always @(posedge clk) begin
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] diff;
    bit               who;
    if (rst) begin
      m_active <= 1'b0;
      m_ptr    <= 1'b0;
      m_owner  <= 1'b0;
      m_load_h <= '0;
    end else if (!m_active) begin
      if (bus.req0 || bus.req1) begin
        if (bus.req0 && bus.req1) who = m_ptr;
        else                      who = bus.req1;
        s    = who ? bus.start1 : bus.start0;
        e    = who ? bus.end1   : bus.end0;
        diff = e - s;
        m_active  <= 1'b1;
        m_owner   <= who;
        m_elapsed <= 0;
        m_len     <= int'(diff) + 1;
        m_load_h  <= s;
      end
    end else if (m_elapsed <= m_len && !(m_owner ? bus.req1 : bus.req0)) begin
      m_active <= 1'b0;
      m_ptr    <= ~m_owner;
    end else if (m_elapsed == m_len + 1) begin
      m_active <= 1'b0;
      m_ptr    <= ~m_owner;
    end else begin
      m_elapsed <= m_elapsed + 1;
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      bit in_done;
      in_done = m_active && (m_elapsed == m_len + 1);
      check_output("gnt0",  int'(bus.gnt0),  int'(m_active && !m_owner));
      check_output("gnt1",  int'(bus.gnt1),  int'(m_active && m_owner));
      check_output("done0", int'(bus.done0), int'(in_done && !m_owner));
      check_output("done1", int'(bus.done1), int'(in_done && m_owner));
      check_output("busy",  int'(bus.busy),  int'(m_active));
      check_output("ctr_load",   int'(bus.ctr_load),   int'(m_active && m_elapsed == 0));
      check_output("ctr_load_h", int'(bus.ctr_load_h), int'(m_load_h));
      check_output("gnt_overlap", int'(bus.gnt0 & bus.gnt1), 0);
      check_output("done_no_gnt",
                   int'((bus.done0 & ~bus.gnt0) | (bus.done1 & ~bus.gnt1)), 0);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input bit r0, input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] e0,
                                input bit r1, input logic [WIDTH-1:0] s1, input logic [WIDTH-1:0] e1);
    bus.req0 = r0; bus.start0 = s0; bus.end0 = e0;
    bus.req1 = r1; bus.start1 = s1; bus.end1 = e1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Counts cycles until the chosen done appears; a timeout is reported as -1.
  task automatic wait_done(input bit which, input int exp_cycles, input string name);
    int got;
    got = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (which ? bus.done1 : bus.done0) begin
        got = n;
        break;
      end
    end
    check_output(name, got, exp_cycles);
  endtask

  task automatic wait_count(input logic [WIDTH-1:0] value, input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (bus.ctr_count == value) begin
        seen = 1'b1;
        break;
      end
    end
    check_output(name, int'(seen), 1);
  endtask

  initial begin
    int wrap_seq [4];
    wrap_seq = '{14, 15, 0, 1};
    apply_stimulus(0, 0, 0, 0, 0, 0);
    step();
    cmp_en = 1'b1;
    step();
    rst = 1'b0;

    $display("[TB] reset state");
    check_output("rst_gnt0", int'(bus.gnt0), 0);
    check_output("rst_busy", int'(bus.busy), 0);
    check_output("rst_load", int'(bus.ctr_load), 0);
    check_output("rst_load_h", int'(bus.ctr_load_h), 0);

    $display("[TB] single run 1..5");
    apply_stimulus(1, 1, 5, 0, 0, 0);
    step();
    check_output("t1_gnt0", int'(bus.gnt0), 1);
    check_output("t1_load", int'(bus.ctr_load), 1);
    check_output("t1_load_h", int'(bus.ctr_load_h), 1);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_output("t1_count", int'(bus.ctr_count), i);
      check_output("t1_no_done", int'(bus.done0), 0);
    end
    step();
    check_output("t1_done0", int'(bus.done0), 1);
    bus.req0 = 1'b0;
    step();
    check_output("t1_idle_gnt0", int'(bus.gnt0), 0);
    check_output("t1_idle_busy", int'(bus.busy), 0);

    $display("[TB] contention from reset");
    do_reset();
    apply_stimulus(1, 0, 2, 1, 7, 8);
    wait_done(0, 5, "t2_done0_first");
    wait_done(1, 5, "t2_done1_second");
    step();
    step();
    check_output("t2_regrant0", int'(bus.gnt0), 1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    step();
    step();

    $display("[TB] wrap 14..1");
    apply_stimulus(0, 0, 0, 1, 14, 1);
    step();
    check_output("t3_gnt1", int'(bus.gnt1), 1);
    check_output("t3_load_h", int'(bus.ctr_load_h), 14);
    for (int i = 0; i < 4; i++) begin
      step();
      check_output("t3_count", int'(bus.ctr_count), wrap_seq[i]);
      check_output("t3_no_done", int'(bus.done1), 0);
    end
    step();
    check_output("t3_done1", int'(bus.done1), 1);
    bus.req1 = 1'b0;
    step();
    check_output("t3_idle", int'(bus.busy), 0);

    $display("[TB] degenerate start==end");
    apply_stimulus(1, 9, 9, 0, 0, 0);
    wait_done(0, 3, "t4_done0_latency");
    bus.req0 = 1'b0;
    step();
    step();

    $display("[TB] abort and pending requester");
    apply_stimulus(1, 0, 10, 0, 0, 0);
    step();
    apply_stimulus(1, 0, 10, 1, 1, 12);
    wait_count(4, "t5_reach4");
    bus.req0 = 1'b0;
    step();
    check_output("t5_abort_gnt0", int'(bus.gnt0), 0);
    check_output("t5_abort_busy", int'(bus.busy), 0);
    check_output("t5_abort_done0", int'(bus.done0), 0);
    step();
    check_output("t5_gnt1", int'(bus.gnt1), 1);
    check_output("t5_load_h", int'(bus.ctr_load_h), 1);

    $display("[TB] reset mid-run");
    wait_count(3, "t6_reach3");
    rst = 1'b1;
    bus.req0 = 1'b1;
    step();
    check_output("t6_gnt1", int'(bus.gnt1), 0);
    check_output("t6_done1", int'(bus.done1), 0);
    check_output("t6_busy", int'(bus.busy), 0);
    check_output("t6_load", int'(bus.ctr_load), 0);
    check_output("t6_load_h", int'(bus.ctr_load_h), 0);
    rst = 1'b0;
    step();
    check_output("t6_gnt0_first", int'(bus.gnt0), 1);
    check_output("t6_gnt1_wait", int'(bus.gnt1), 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cload_arbiter.md
Name: cload_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared loadable up-counter (`counter_load`). A granted requester supplies a start and an end value. The arbiter loads the counter with the start value, watches the count until it reaches the end value, pulses done to that requester, then releases the counter. It sits between client logic and one `counter_load` instance, and is the only driver of the counter's load/load_h inputs.

Parameters:
WIDTH, 4, width of counter value, start/end operands and ctr_load_h/ctr_count

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req0  input  1  requester 0 run request (level, held until done0 or abort)
start0  input  WIDTH  requester 0 start value
end0  input  WIDTH  requester 0 end (terminal) value
req1  input  1  requester 1 run request
start1  input  WIDTH  requester 1 start value
end1  input  WIDTH  requester 1 end value
gnt0  output  1  requester 0 owns counter (LOAD..DONE)
gnt1  output  1  requester 1 owns counter
done0  output  1  one-cycle pulse: requester 0 run complete
done1  output  1  one-cycle pulse: requester 1 run complete
busy  output  1  high whenever state != IDLE
ctr_load  output  1  to counter load
ctr_load_h  output  WIDTH  to counter load_h
ctr_count  input  WIDTH  from counter count

Behaviour:
- Counter model:
  - On an edge with load=1, count <= load_h.
  - Otherwise count <= count+1 mod 2^WIDTH (wraps max->0).
- All outputs are registered.
- Reset:
  - state=IDLE; gnt0, gnt1, done0, done1, busy, ctr_load = 0; ctr_load_h = 0.
  - Round-robin pointer cleared so requester 0 has priority.
  - Latched start/end cleared.
  - Reset mid-operation aborts the run immediately: no done pulse, pointer cleared.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - No req: stay.
  - Only one req high: grant it.
  - Both high: grant the one that was not granted last. After reset, requester 0 wins.
  - On grant, latch that requester's start/end. Next state LOAD, with gntN=1, busy=1, ctr_load=1, ctr_load_h=start.
  - start/end are sampled only on the grant edge; later changes are ignored.
- LOAD:
  - Lasts exactly one cycle; the counter loads start on the exiting edge.
  - Next state RUN with ctr_load=0. ctr_load_h holds its value.
- RUN:
  - Compare ctr_count == latched end each cycle. On match, next state DONE with doneN=1.
  - Counter counts freely, including wrap. RUN therefore lasts ((end-start) mod 2^WIDTH)+1 cycles, maximum 2^WIDTH.
  - start==end matches on the first RUN cycle.
- DONE:
  - One cycle; doneN high for exactly this cycle.
  - Next state IDLE: gntN=0, busy=0, pointer records N as last granted.
- Latency: req sampled at edge e0, then:
  - LOAD during e0..e1.
  - First RUN cycle shows count=start.
  - doneN high in the cycle after e(2+d), where d=(end-start) mod 2^WIDTH.
- Abort: if the granted requester's req is low during LOAD or RUN, next state IDLE.
  - No done pulse; gnt, busy and ctr_load cleared.
  - Pointer records N as last granted.
- Requester protocol: drop req in the cycle after done. A req still high in IDLE is treated as a new request and is arbitrated normally, so a continuously asserting pair alternates.
- Non-granted req may toggle freely without effect.
- gnt0 and gnt1 are never both high; done is never asserted without the matching gnt.
- Counter activity while IDLE (free running) is ignored.

Test Plan:
1. Single run: req0=1, start0=1, end0=5 after reset.
   - Expect: gnt0 high next cycle with ctr_load=1, ctr_load_h=1; count sequence 1..5.
   - Expect: done0 pulse one cycle after count=5 observed; then IDLE with gnt0=0, busy=0.
2. Contention from reset: req0 and req1 both held high.
   - req0 start=0, end=2; req1 start=7, end=8.
   - Expect: requester 0 served first (done0), then requester 1 (done1 after count 7,8), then requester 0 again. Grants never overlap.
3. Wrap: req1, start1=14, end1=1.
   - Expect: counts 14, 15, 0, 1 (RUN=4 cycles); done1 then IDLE.
4. Degenerate: req0, start0=end0=9.
   - Expect: RUN lasts 1 cycle; done0 high 3 cycles after req sampled.
5. Abort: req0, start0=0, end0=10; drop req0 when count=4.
   - Expect: next cycle IDLE, no done0. A pending req1 is granted next (pointer advanced).
6. Reset mid-RUN: assert rst for one cycle at count=3 during a req1 run.
   - Expect: all outputs 0 next cycle, no done1. With both reqs high after reset, requester 0 is granted first.
